// File: rtl/dac_mux_scheduler.sv
// Round-robin scheduler that shares one 8-bit DAC across NCH sample-and-hold
// channels, driven from a host-writable per-channel code register file.
module dac_mux_scheduler #(
    parameter int NCH        = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CHW        = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [CHW-1:0] wr_ch,
    input  logic [7:0]     wr_code,
    output logic [7:0]     dac_code,
    output logic [NCH-1:0] sh_strobe,
    output logic [CHW-1:0] cur_ch,
    output logic           busy,
    output logic           frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int             DEPTH       = 2 ** CHW;
    localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [CHW-1:0] LAST_CH     = CHW'(NCH - 1);

    state_t         state_r, state_nx_s;
    logic [7:0]     settle_cnt_r, settle_cnt_nx_s;
    logic [CHW-1:0] cur_ch_r, cur_ch_nx_s;
    logic [7:0]     dac_code_r, dac_code_nx_s;
    logic [NCH-1:0] sh_strobe_r, sh_strobe_nx_s;
    logic           frame_done_r, frame_done_nx_s;
    logic           busy_r;
    logic           wr_ready_r;
    logic           wr_fire_s;
    logic           wr_in_range_s;
    logic           bypass_s;
    logic [7:0]     code_r [DEPTH];

    // Out-of-range channels are still handshaken but never stored.
    assign wr_fire_s     = wr_valid && wr_ready_r;
    assign wr_in_range_s = int'(wr_ch) < NCH;
    assign bypass_s      = wr_fire_s && (wr_ch == cur_ch_r);

    assign wr_ready   = wr_ready_r;
    assign dac_code   = dac_code_r;
    assign sh_strobe  = sh_strobe_r;
    assign cur_ch     = cur_ch_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Host write port: code register file and the always-ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                code_r[i] <= 8'h00;
            end
        end else begin
            wr_ready_r <= 1'b1;
            if (wr_fire_s && wr_in_range_s) begin
                code_r[wr_ch] <= wr_code;
            end
        end
    end

    // Scan state and registered DAC/strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            settle_cnt_r <= 8'd0;
            cur_ch_r     <= '0;
            dac_code_r   <= 8'h00;
            sh_strobe_r  <= '0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            settle_cnt_r <= settle_cnt_nx_s;
            cur_ch_r     <= cur_ch_nx_s;
            dac_code_r   <= dac_code_nx_s;
            sh_strobe_r  <= sh_strobe_nx_s;
            frame_done_r <= frame_done_nx_s;
            busy_r       <= (state_nx_s != IDLE);
        end
    end

    // Next-state logic; strobe and frame_done are computed one cycle ahead
    // so their registered copies line up with HOLD and the cycle after it.
    always_comb begin
        state_nx_s      = state_r;
        settle_cnt_nx_s = settle_cnt_r;
        cur_ch_nx_s     = cur_ch_r;
        dac_code_nx_s   = dac_code_r;
        sh_strobe_nx_s  = '0;
        frame_done_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nx_s  = LOAD;
                    cur_ch_nx_s = '0;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            LOAD: begin
                state_nx_s      = SETTLE;
                settle_cnt_nx_s = 8'd0;
                if (bypass_s) begin
                    dac_code_nx_s = wr_code;
                end else begin
                    dac_code_nx_s = code_r[cur_ch_r];
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_nx_s     = HOLD;
                    sh_strobe_nx_s = NCH'(1) << cur_ch_r;
                end else begin
                    settle_cnt_nx_s = settle_cnt_r + 8'd1;
                end
            end
            HOLD: begin
                if (cur_ch_r == LAST_CH) begin
                    frame_done_nx_s = 1'b1;
                    cur_ch_nx_s     = '0;
                    if (enable) begin
                        state_nx_s = LOAD;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    cur_ch_nx_s = cur_ch_r + CHW'(1);
                    state_nx_s  = LOAD;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_mux_scheduler.sv
// Directed bench for dac_mux_scheduler: a default 4-channel/8-cycle instance
// and a 5-channel/1-cycle instance for short settle and out-of-range writes.
module tb_dac_mux_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, wr_valid, wr_ready;
    logic [1:0] wr_ch;
    logic [7:0] wr_code, dac_code;
    logic [3:0] sh_strobe;
    logic [1:0] cur_ch;
    logic       busy, frame_done;

    logic       enable_b, wr_valid_b, wr_ready_b;
    logic [2:0] wr_ch_b;
    logic [7:0] wr_code_b, dac_code_b;
    logic [4:0] sh_strobe_b;
    logic [2:0] cur_ch_b;
    logic       busy_b, frame_done_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] code_a [4];
    logic [7:0] code_b [5];

    always #5 clk = ~clk;

    dac_mux_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_code(wr_code),
        .dac_code(dac_code), .sh_strobe(sh_strobe), .cur_ch(cur_ch),
        .busy(busy), .frame_done(frame_done)
    );

    dac_mux_scheduler #(.NCH(5), .SETTLE_CYC(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_ch(wr_ch_b), .wr_code(wr_code_b),
        .dac_code(dac_code_b), .sh_strobe(sh_strobe_b), .cur_ch(cur_ch_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    task automatic write_a(input int ch, input logic [7:0] code);
        @(negedge clk);
        wr_valid = 1'b1; wr_ch = 2'(ch); wr_code = code;
        code_a[ch] = code;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic write_b(input int ch, input logic [7:0] code);
        @(negedge clk);
        vectors++;
        if (wr_ready_b !== 1'b1) begin
            miscompares++; $display("FAIL wr_ready_b ch=%0d got %b want 1", ch, wr_ready_b);
        end
        wr_valid_b = 1'b1; wr_ch_b = 3'(ch); wr_code_b = code;
        if (ch < 5) code_b[ch] = code;
        @(negedge clk);
        wr_valid_b = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        vectors++;
        if ({dac_code, sh_strobe, cur_ch, busy, frame_done} !== 16'h0000) begin
            miscompares++; $display("FAIL reset_a_outputs got %h want 0000", {dac_code, sh_strobe, cur_ch, busy, frame_done});
        end
        vectors++;
        if (wr_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_wr_ready got %b want 0", wr_ready);
        end
        vectors++;
        if ({dac_code_b, sh_strobe_b, cur_ch_b, busy_b, frame_done_b, wr_ready_b} !== 19'h0) begin
            miscompares++; $display("FAIL reset_b_outputs got %h want 0", {dac_code_b, sh_strobe_b, cur_ch_b, busy_b, frame_done_b, wr_ready_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (wr_ready !== 1'b1 || wr_ready_b !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_wr_ready got %b%b want 11", wr_ready, wr_ready_b);
        end
        vectors++;
        if (busy !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_busy got %b%b want 00", busy, busy_b);
        end
    endtask

    task automatic test_frame;
        logic [7:0] last, hold, exp_dac;
        logic [3:0] exp_stb;
        int ch, ph, n;
        write_a(0, 8'h10); write_a(1, 8'h80); write_a(2, 8'hFF); write_a(3, 8'h00);
        @(negedge clk);
        enable = 1'b1;
        last = 8'h00; hold = 8'h00;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            ch = (t / 10) % 4; ph = t % 10;
            exp_dac = (ph == 0) ? last : hold;
            exp_stb = (ph == 9) ? 4'(1 << ch) : 4'd0;
            vectors++;
            if (dac_code !== exp_dac) begin
                miscompares++; $display("FAIL frame_dac t=%0d got %02h want %02h", t, dac_code, exp_dac);
            end
            vectors++;
            if (sh_strobe !== exp_stb) begin
                miscompares++; $display("FAIL frame_strobe t=%0d got %b want %b", t, sh_strobe, exp_stb);
            end
            vectors++;
            if (cur_ch !== 2'(ch) || busy !== 1'b1) begin
                miscompares++; $display("FAIL frame_ch_busy t=%0d got %0d/%b want %0d/1", t, cur_ch, busy, ch);
            end
            vectors++;
            if (frame_done !== (t == 40)) begin
                miscompares++; $display("FAIL frame_done t=%0d got %b want %b", t, frame_done, (t == 40));
            end
            if (ph == 0) hold = code_a[ch];
            if (ph == 9) last = hold;
        end
        enable = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n != 40) begin
            miscompares++; $display("FAIL frame2_to_idle cycles got %0d want 40", n);
        end
    endtask

    task automatic test_bypass;
        logic [7:0] last, hold, exp_dac;
        logic [3:0] exp_stb;
        int ch, ph, n;
        @(negedge clk);
        enable = 1'b1;
        last = 8'h00; hold = 8'h00;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            ch = (t / 10) % 4; ph = t % 10;
            exp_dac = (ph == 0) ? last : hold;
            exp_stb = (ph == 9) ? 4'(1 << ch) : 4'd0;
            vectors++;
            if (dac_code !== exp_dac) begin
                miscompares++; $display("FAIL bypass_dac t=%0d got %02h want %02h", t, dac_code, exp_dac);
            end
            vectors++;
            if (sh_strobe !== exp_stb) begin
                miscompares++; $display("FAIL bypass_strobe t=%0d got %b want %b", t, sh_strobe, exp_stb);
            end
            if (t == 11 || t == 19) begin
                vectors++;
                if (dac_code !== 8'h55) begin
                    miscompares++; $display("FAIL bypass_same_cycle t=%0d got %02h want 55", t, dac_code);
                end
            end
            if (t == 51) begin
                vectors++;
                if (dac_code !== 8'h66) begin
                    miscompares++; $display("FAIL bypass_next_frame got %02h want 66", dac_code);
                end
            end
            wr_valid = 1'b0;
            if (t == 10) begin
                wr_valid = 1'b1; wr_ch = 2'd1; wr_code = 8'h55; code_a[1] = 8'h55;
            end
            if (t == 13) begin
                wr_valid = 1'b1; wr_ch = 2'd1; wr_code = 8'h66; code_a[1] = 8'h66;
            end
            if (t == 41) enable = 1'b0;
            if (ph == 0) hold = code_a[ch];
            if (ph == 9) last = hold;
        end
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n != 21) begin
            miscompares++; $display("FAIL bypass_to_idle cycles got %0d want 21", n);
        end
    endtask

    task automatic test_enable_drop;
        logic [7:0] last, hold, exp_dac;
        logic [3:0] exp_stb;
        int ch, ph;
        write_a(3, 8'h3C);
        @(negedge clk);
        enable = 1'b1;
        last = 8'h00; hold = 8'h00;
        for (int t = 0; t <= 44; t++) begin
            @(negedge clk);
            ch = (t / 10) % 4; ph = t % 10;
            exp_dac = (ph == 0) ? last : hold;
            exp_stb = (ph == 9) ? 4'(1 << ch) : 4'd0;
            vectors++;
            if (dac_code !== exp_dac) begin
                miscompares++; $display("FAIL drop_dac t=%0d got %02h want %02h", t, dac_code, exp_dac);
            end
            vectors++;
            if (sh_strobe !== exp_stb || cur_ch !== 2'(ch)) begin
                miscompares++; $display("FAIL drop_strobe_ch t=%0d got %b/%0d want %b/%0d", t, sh_strobe, cur_ch, exp_stb, ch);
            end
            vectors++;
            if (busy !== (t < 40) || frame_done !== (t == 40)) begin
                miscompares++; $display("FAIL drop_busy_done t=%0d got %b%b want %b%b", t, busy, frame_done, (t < 40), (t == 40));
            end
            if (t == 12) enable = 1'b0;
            if (ph == 0 && t < 40) hold = code_a[ch];
            if (ph == 9) last = hold;
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] last, hold, exp_dac;
        logic [3:0] exp_stb;
        int ch, ph, n;
        @(negedge clk);
        enable = 1'b1;
        last = 8'h3C; hold = 8'h3C;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            ch = (t / 10) % 4; ph = t % 10;
            exp_dac = (ph == 0) ? last : hold;
            vectors++;
            if (dac_code !== exp_dac) begin
                miscompares++; $display("FAIL prereset_dac t=%0d got %02h want %02h", t, dac_code, exp_dac);
            end
            if (ph == 0) hold = code_a[ch];
            if (ph == 9) last = hold;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({dac_code, sh_strobe, cur_ch, busy, frame_done, wr_ready} !== 17'h0) begin
            miscompares++; $display("FAIL async_reset_outputs got %h want 0", {dac_code, sh_strobe, cur_ch, busy, frame_done, wr_ready});
        end
        for (int i = 0; i < 4; i++) code_a[i] = 8'h00;
        for (int i = 0; i < 5; i++) code_b[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            ch = (t / 10) % 4; ph = t % 10;
            exp_stb = (ph == 9) ? 4'(1 << ch) : 4'd0;
            vectors++;
            if (dac_code !== 8'h00 || sh_strobe !== exp_stb) begin
                miscompares++; $display("FAIL restart_dac_strobe t=%0d got %02h/%b want 00/%b", t, dac_code, sh_strobe, exp_stb);
            end
            vectors++;
            if (cur_ch !== 2'(ch) || busy !== 1'b1 || wr_ready !== 1'b1) begin
                miscompares++; $display("FAIL restart_ch_busy t=%0d got %0d/%b/%b want %0d/1/1", t, cur_ch, busy, wr_ready, ch);
            end
        end
        enable = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n != 21) begin
            miscompares++; $display("FAIL restart_to_idle cycles got %0d want 21", n);
        end
    endtask

    task automatic test_settle1;
        logic [7:0] last, hold, exp_dac;
        logic [4:0] exp_stb;
        int ch, ph, n;
        write_b(0, 8'h11); write_b(1, 8'h22); write_b(2, 8'h33); write_b(3, 8'h44); write_b(4, 8'h5A);
        write_b(5, 8'hEE); write_b(7, 8'hEE);
        @(negedge clk);
        enable_b = 1'b1;
        last = 8'h00; hold = 8'h00;
        for (int t = 0; t <= 15; t++) begin
            @(negedge clk);
            ch = (t / 3) % 5; ph = t % 3;
            exp_dac = (ph == 0) ? last : hold;
            exp_stb = (ph == 2) ? 5'(1 << ch) : 5'd0;
            vectors++;
            if (dac_code_b !== exp_dac) begin
                miscompares++; $display("FAIL settle1_dac t=%0d got %02h want %02h", t, dac_code_b, exp_dac);
            end
            vectors++;
            if (sh_strobe_b !== exp_stb || cur_ch_b !== 3'(ch)) begin
                miscompares++; $display("FAIL settle1_strobe_ch t=%0d got %b/%0d want %b/%0d", t, sh_strobe_b, cur_ch_b, exp_stb, ch);
            end
            vectors++;
            if (busy_b !== 1'b1 || frame_done_b !== (t == 15)) begin
                miscompares++; $display("FAIL settle1_busy_done t=%0d got %b%b want 1%b", t, busy_b, frame_done_b, (t == 15));
            end
            if (ph == 0) hold = code_b[ch];
            if (ph == 2) last = hold;
        end
        enable_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n != 15) begin
            miscompares++; $display("FAIL settle1_to_idle cycles got %0d want 15", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b0; wr_valid = 1'b0; wr_ch = 2'd0; wr_code = 8'h00;
        enable_b = 1'b0; wr_valid_b = 1'b0; wr_ch_b = 3'd0; wr_code_b = 8'h00;
        for (int i = 0; i < 4; i++) code_a[i] = 8'h00;
        for (int i = 0; i < 5; i++) code_b[i] = 8'h00;
        test_reset;
        test_frame;
        test_bypass;
        test_enable_drop;
        test_async_reset;
        test_settle1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
